// File: rtl/seg_scan_decoder_if.sv
// Scan-bus bundle between a 7-segment display driver and the scan decoder.
// The decoder side uses the slave modport; a driver or bench uses master.
interface seg_scan_decoder_if;
    logic [7:0]  dig_i;
    logic [7:0]  seg_i;
    logic [31:0] digits_o;
    logic [7:0]  dp_o;
    logic        frame_valid_o;
    logic        seg_err_o;
    logic        stale_o;

    modport slave (
        input  dig_i,
        input  seg_i,
        output digits_o,
        output dp_o,
        output frame_valid_o,
        output seg_err_o,
        output stale_o
    );

    modport master (
        output dig_i,
        output seg_i,
        input  digits_o,
        input  dp_o,
        input  frame_valid_o,
        input  seg_err_o,
        input  stale_o
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers eight BCD digits and decimal points from a multiplexed 7-segment scan bus,
// publishing a whole frame at once with a one-cycle valid pulse.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input logic               clk,
    input logic               rst,
    seg_scan_decoder_if.slave scan_io
);
    localparam int unsigned    ToW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ToW-1:0] ToMax     = ToW'(TIMEOUT_CYC);
    localparam logic [7:0]     SettleMax = 8'(SETTLE_CYC);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSettle = 2'd1;
    localparam logic [1:0] StHold   = 2'd2;

    logic [7:0]     dig_s1_q, dig_s2_q, seg_s1_q, seg_s2_q;
    logic [1:0]     state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [31:0]    shadow_q, shadow_d;
    logic [7:0]     sdp_q, sdp_d, serr_q, serr_d, mask_q, mask_d;
    logic [31:0]    digits_q, digits_d;
    logic [7:0]     dp_q, dp_d;
    logic           valid_q, valid_d, err_q, err_d, stale_q, stale_d;
    logic [ToW-1:0] to_q, to_d;

    logic [7:0] sel_inv;
    logic       legal;
    logic [2:0] sel_idx;
    logic       restart, advance, cap, pub;
    logic [3:0] dec_val;
    logic       dec_err;

    // Select decode: legal means exactly one active-low bit.
    always_comb begin
        sel_inv = ~dig_s2_q;
        legal   = (|sel_inv) && ~|(sel_inv & (sel_inv - 8'd1));
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel_inv[i]) sel_idx = 3'(i);
        end
    end

    always_comb begin
        dec_err = 1'b0;
        case (seg_s2_q[6:0])
            7'h40:   dec_val = 4'h0;
            7'h79:   dec_val = 4'h1;
            7'h24:   dec_val = 4'h2;
            7'h30:   dec_val = 4'h3;
            7'h19:   dec_val = 4'h4;
            7'h12:   dec_val = 4'h5;
            7'h02:   dec_val = 4'h6;
            7'h78:   dec_val = 4'h7;
            7'h00:   dec_val = 4'h8;
            7'h10:   dec_val = 4'h9;
            7'h7F:   dec_val = 4'hA;
            default: begin
                dec_val = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        restart = 1'b0;
        advance = 1'b0;
        cap     = 1'b0;
        case (state_q)
            StIdle:   restart = legal;
            StSettle: begin
                if (!legal)                    state_d = StIdle;
                else if (sel_idx != idx_q)     restart = 1'b1;
                else                           advance = 1'b1;
            end
            StHold: begin
                if (!legal)                    state_d = StIdle;
                else if (sel_idx != idx_q)     restart = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        if (restart) begin
            cnt_d   = 8'd1;
            idx_d   = sel_idx;
            state_d = StSettle;
        end
        if (advance) cnt_d = cnt_q + 8'd1;
        if ((restart || advance) && (cnt_d == SettleMax)) begin
            cap     = 1'b1;
            state_d = StHold;
        end
    end

    // Publication reads the old shadow; a same-cycle capture lands in the next frame.
    always_comb begin
        pub      = (mask_q == 8'hFF);
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        serr_d   = serr_q;
        mask_d   = pub ? 8'h00 : mask_q;
        if (cap) begin
            shadow_d[{idx_d, 2'b00} +: 4] = dec_val;
            sdp_d[idx_d]                  = ~seg_s2_q[7];
            serr_d[idx_d]                 = dec_err;
            mask_d[idx_d]                 = 1'b1;
        end
        digits_d = pub ? shadow_q : digits_q;
        dp_d     = pub ? sdp_q : dp_q;
        err_d    = pub ? |serr_q : err_q;
        valid_d  = pub;
        if (pub)                to_d = '0;
        else if (to_q == ToMax) to_d = to_q;
        else                    to_d = to_q + ToW'(1);
        stale_d  = (to_d == ToMax);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_s1_q <= 8'hFF;
            dig_s2_q <= 8'hFF;
            seg_s1_q <= 8'hFF;
            seg_s2_q <= 8'hFF;
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            idx_q    <= 3'd0;
            shadow_q <= 32'd0;
            sdp_q    <= 8'd0;
            serr_q   <= 8'd0;
            mask_q   <= 8'd0;
            digits_q <= 32'd0;
            dp_q     <= 8'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            stale_q  <= 1'b0;
            to_q     <= '0;
        end else begin
            dig_s1_q <= scan_io.dig_i;
            dig_s2_q <= dig_s1_q;
            seg_s1_q <= scan_io.seg_i;
            seg_s2_q <= seg_s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
            serr_q   <= serr_d;
            mask_q   <= mask_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            stale_q  <= stale_d;
            to_q     <= to_d;
        end
    end

    assign scan_io.digits_o      = digits_q;
    assign scan_io.dp_o          = dp_q;
    assign scan_io.frame_valid_o = valid_q;
    assign scan_io.seg_err_o     = err_q;
    assign scan_io.stale_o       = stale_q;
endmodule
